// File: rtl/cap_err_inj_sched.sv
// cap_err_inj_sched: picks which LSU access (CLC/CSC or RV32 ld/st) gets an
// injected CHERI capability fault and which fault type it gets. It owns a
// seedable Galois LFSR and the burst state, flags injections that reached
// the bus untrapped, and keeps saturating injection/failure counters.
//
// Handshake: an access on channel n is present while acc_valid_i[n] is high
// and completes in the cycle acc_done_i[n] is high; inj_active_o[n] is only
// meaningful while acc_valid_i[n] is high, and the fault is applied for
// exactly the cycles it is asserted.
module cap_err_inj_sched #(
   parameter int NCHAN  = 2,
   parameter int RATE_W = 3,
   parameter int CNT_W  = 16,
   parameter int ARM_TO = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_en_i,
   input  logic [RATE_W-1:0] cfg_rate_i,
   input  logic [4:0]        cfg_type_mask_i,
   input  logic [3:0]        cfg_burst_i,
   input  logic [31:0]       cfg_seed_i,
   input  logic              cfg_seed_ld_i,
   input  logic [NCHAN-1:0]  acc_valid_i,
   input  logic [NCHAN-1:0]  acc_is_cap_i,
   input  logic [NCHAN-1:0]  acc_done_i,
   input  logic              in_isr_i,
   input  logic              lsu_req_i,
   input  logic              lsu_cheri_err_i,
   input  logic              skip_chk_i,
   output logic [NCHAN-1:0]  inj_active_o,
   output logic [2:0]        inj_type_o,
   output logic [31:0]       inj_seed_o,
   output logic              err_failed_o,
   output logic [CNT_W-1:0]  inj_cnt_o,
   output logic [CNT_W-1:0]  fail_cnt_o,
   output logic [1:0]        dbg_state_o
);

   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int AW = (ARM_TO > 1) ? $clog2(ARM_TO) : 1;
   // Right-shifting Galois form of x^32+x^22+x^2+x+1.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_INJECT = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       lfsr;
   logic [31:0]       lfsr_adv;
   logic [CW-1:0]     chan;
   logic [31:0]       seed_q;
   logic [3:0]        burst_left;
   logic [AW-1:0]     arm_cnt;
   logic [2:0]        inj_type_q;
   logic              fail_seen;
   logic              err_failed_q;
   logic [CNT_W-1:0]  inj_cnt_q;
   logic [CNT_W-1:0]  fail_cnt_q;

   logic              done_hit;
   logic [CW-1:0]     done_idx;
   logic [7:0]        rate_mask;
   logic              arm_go;
   logic              cls_cap;
   logic [3:0]        ncls;
   logic [2:0]        base;
   logic [3:0]        cand;
   logic              type_ok;
   logic [2:0]        type_sel;
   logic              inj_go;
   logic              arm_expire;
   logic              last_burst;
   logic              inj_done;
   logic              enter_inject;
   logic              fail_hit;

   // LFSR step; a zero seed would lock the register, so it loads as 1.
   always_comb begin
      lfsr_adv = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
   end

   // LFSR register: seed load wins over advancing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 32'h1;
      end else if (cfg_seed_ld_i) begin
         lfsr <= (cfg_seed_i == 32'h0) ? 32'h1 : cfg_seed_i;
      end else begin
         lfsr <= lfsr_adv;
      end
   end

   // Trigger: lowest completing channel, gated by the rate roll on lfsr[7-rate:0].
   always_comb begin
      done_hit = 1'b0;
      done_idx = '0;
      for (int n = NCHAN - 1; n >= 0; n--) begin
         if (acc_valid_i[n] && acc_done_i[n]) begin
            done_hit = 1'b1;
            done_idx = CW'(n);
         end
      end
      rate_mask = 8'hFF >> cfg_rate_i;
      arm_go    = cfg_en_i && (cfg_rate_i != '0) && done_hit &&
                  ((lfsr[7:0] & rate_mask) == 8'h00);
   end

   // Fault type: seed picks a start point, masked types roll upward within the class.
   always_comb begin
      cls_cap  = acc_is_cap_i[chan];
      ncls     = cls_cap ? 4'd5 : 4'd4;
      base     = cls_cap ? 3'(seed_q[15:0] % 16'd5) : {1'b0, seed_q[1:0]};
      type_ok  = 1'b0;
      type_sel = 3'd0;
      cand     = 4'd0;
      for (int k = 0; k < 5; k++) begin
         if (4'(k) < ncls) begin
            cand = {1'b0, base} + 4'(k);
            if (cand >= ncls) begin
               cand = cand - ncls;
            end
            if (!type_ok && cfg_type_mask_i[cand[2:0]]) begin
               type_ok  = 1'b1;
               type_sel = cand[2:0];
            end
         end
      end
   end

   // Qualifiers shared by the FSM and datapath.
   always_comb begin
      inj_go       = acc_valid_i[chan] && !in_isr_i && type_ok;
      arm_expire   = (arm_cnt == AW'(ARM_TO - 1));
      last_burst   = (burst_left <= 4'd1);
      inj_done     = cfg_en_i && (state == S_INJECT) && acc_done_i[chan];
      enter_inject = (state == S_ARMED) && (state_nxt == S_INJECT);
      fail_hit     = (|inj_active_o) && lsu_req_i && !lsu_cheri_err_i &&
                     !skip_chk_i && !fail_seen;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; disabling the block always returns to IDLE.
   always_comb begin
      state_nxt = state;
      if (!cfg_en_i) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (arm_go) state_nxt = S_ARMED;
            end
            S_ARMED: begin
               if (inj_go)          state_nxt = S_INJECT;
               else if (arm_expire) state_nxt = S_IDLE;
            end
            S_INJECT: begin
               if (acc_done_i[chan]) state_nxt = last_burst ? S_IDLE : S_ARMED;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM outputs: fault strobe per channel and the debug state.
   always_comb begin
      for (int n = 0; n < NCHAN; n++) begin
         inj_active_o[n] = cfg_en_i && (state == S_INJECT) && (chan == CW'(n)) &&
                           acc_valid_i[n] && !in_isr_i;
      end
      dbg_state_o = state;
   end

   // Datapath: arm context, burst bookkeeping, type latch, failure detect, counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan         <= '0;
         seed_q       <= '0;
         burst_left   <= '0;
         arm_cnt      <= '0;
         inj_type_q   <= '0;
         fail_seen    <= 1'b0;
         err_failed_q <= 1'b0;
         inj_cnt_q    <= '0;
         fail_cnt_q   <= '0;
      end else begin
         arm_cnt <= (state == S_ARMED && state_nxt == S_ARMED) ? arm_cnt + 1'b1 : '0;

         if (!cfg_en_i) begin
            burst_left <= '0;
         end else if (state == S_IDLE && arm_go) begin
            chan       <= done_idx;
            seed_q     <= lfsr;
            burst_left <= (cfg_burst_i == 4'd0) ? 4'd1 : cfg_burst_i;
         end else if (inj_done) begin
            burst_left <= burst_left - 4'd1;
            if (!last_burst) seed_q <= lfsr;
         end

         if (enter_inject) begin
            inj_type_q <= type_sel;
            fail_seen  <= 1'b0;
         end else if (fail_hit) begin
            fail_seen  <= 1'b1;
         end

         if (inj_done && inj_cnt_q != '1) inj_cnt_q <= inj_cnt_q + 1'b1;

         err_failed_q <= fail_hit;
         if (fail_hit && fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + 1'b1;
      end
   end

   assign inj_type_o   = inj_type_q;
   assign inj_seed_o   = seed_q;
   assign err_failed_o = err_failed_q;
   assign inj_cnt_o    = inj_cnt_q;
   assign fail_cnt_o   = fail_cnt_q;

endmodule

// File: tb/tb_cap_err_inj_sched.sv
// tb_cap_err_inj_sched: directed vectors plus multi-cycle sequences for the
// capability-error injection scheduler. Inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_cap_err_inj_sched;

   localparam int NCHAN  = 2;
   localparam int RATE_W = 3;
   localparam int CNT_W  = 6;
   localparam int ARM_TO = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_INJECT = 2'd2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_en;
   logic [RATE_W-1:0] cfg_rate;
   logic [4:0]        cfg_type_mask;
   logic [3:0]        cfg_burst;
   logic [31:0]       cfg_seed;
   logic              cfg_seed_ld;
   logic [NCHAN-1:0]  acc_valid;
   logic [NCHAN-1:0]  acc_is_cap;
   logic [NCHAN-1:0]  acc_done;
   logic              in_isr;
   logic              lsu_req;
   logic              lsu_cheri_err;
   logic              skip_chk;
   logic [NCHAN-1:0]  inj_active;
   logic [2:0]        inj_type;
   logic [31:0]       inj_seed;
   logic              err_failed;
   logic [CNT_W-1:0]  inj_cnt;
   logic [CNT_W-1:0]  fail_cnt;
   logic [1:0]        dbg_state;

   cap_err_inj_sched #(
      .NCHAN(NCHAN), .RATE_W(RATE_W), .CNT_W(CNT_W), .ARM_TO(ARM_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_en_i(cfg_en), .cfg_rate_i(cfg_rate), .cfg_type_mask_i(cfg_type_mask),
      .cfg_burst_i(cfg_burst), .cfg_seed_i(cfg_seed), .cfg_seed_ld_i(cfg_seed_ld),
      .acc_valid_i(acc_valid), .acc_is_cap_i(acc_is_cap), .acc_done_i(acc_done),
      .in_isr_i(in_isr), .lsu_req_i(lsu_req), .lsu_cheri_err_i(lsu_cheri_err),
      .skip_chk_i(skip_chk),
      .inj_active_o(inj_active), .inj_type_o(inj_type), .inj_seed_o(inj_seed),
      .err_failed_o(err_failed), .inj_cnt_o(inj_cnt), .fail_cnt_o(fail_cnt),
      .dbg_state_o(dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         exp_inj_total = 0;
   bit         sb_on = 1'b0;
   logic [3:0] exp_q[$];

   typedef struct {
      int          ch;
      bit          cap;
      logic [31:0] seed;
      logic [2:0]  rate;
      logic [4:0]  mask;
      logic [3:0]  burst;
      bit          arms;
      bit          injects;
      logic [2:0]  typ;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int n);
      return (n > CNT_MAX) ? CNT_MAX : n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      acc_valid = '0; acc_done = '0; acc_is_cap = '0;
      in_isr = 1'b0; lsu_req = 1'b0; lsu_cheri_err = 1'b0; skip_chk = 1'b0;
      cfg_seed_ld = 1'b0;
   endtask

   task automatic flush();
      cfg_en = 1'b0;
      tick();
      cfg_en = 1'b1;
   endtask

   task automatic load_seed(input logic [31:0] s);
      cfg_seed = s;
      cfg_seed_ld = 1'b1;
      tick();
      cfg_seed_ld = 1'b0;
   endtask

   task automatic arm(input int ch, input bit cap);
      acc_valid[ch] = 1'b1; acc_done[ch] = 1'b1; acc_is_cap[ch] = cap;
      tick();
      acc_valid = '0; acc_done = '0;
   endtask

   task automatic expect_inj(input int ch, input logic [2:0] typ);
      exp_q.push_back({ch[0], typ});
      exp_inj_total++;
   endtask

   // Access on ch while ARMED: one cycle to enter INJECT, one cycle completing.
   task automatic inject_access(input int ch);
      acc_valid[ch] = 1'b1;
      tick();
      acc_done[ch] = 1'b1;
      tick();
      acc_valid = '0; acc_done = '0;
   endtask

   // Scoreboard: every completing injected access pops one expected {chan, type}.
   always @(negedge clk) begin
      logic [3:0] got;
      logic [3:0] exp;
      if (sb_on && rst_n && ((inj_active & acc_done) != '0)) begin
         got = {inj_active[1], inj_type};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected_inj: got chan/type %0h expected none", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               n_errors++;
               $display("FAIL sb_inj: got chan/type %0h expected %0h", got, exp);
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int n_inj;
      int base_cnt;

      vecs[0]  = '{0, 1'b0, 32'h0000_0004, 3'd7, 5'h1F, 4'd1, 1'b1, 1'b1, 3'd0};
      vecs[1]  = '{1, 1'b0, 32'h0000_0006, 3'd7, 5'h1F, 4'd0, 1'b1, 1'b1, 3'd2};
      vecs[2]  = '{0, 1'b1, 32'h0000_0008, 3'd7, 5'h1F, 4'd1, 1'b1, 1'b1, 3'd3};
      vecs[3]  = '{1, 1'b1, 32'h0000_000E, 3'd7, 5'h1F, 4'd1, 1'b1, 1'b1, 3'd4};
      vecs[4]  = '{0, 1'b0, 32'h0000_000A, 3'd7, 5'h02, 4'd1, 1'b1, 1'b1, 3'd1};
      vecs[5]  = '{0, 1'b1, 32'h0000_0010, 3'd7, 5'h01, 4'd1, 1'b1, 1'b1, 3'd0};
      vecs[6]  = '{1, 1'b0, 32'h0000_0004, 3'd7, 5'h10, 4'd1, 1'b1, 1'b0, 3'd0};
      vecs[7]  = '{0, 1'b0, 32'h0000_0003, 3'd7, 5'h1F, 4'd1, 1'b0, 1'b0, 3'd0};
      vecs[8]  = '{1, 1'b1, 32'hFFFF_0012, 3'd7, 5'h10, 4'd1, 1'b1, 1'b1, 3'd4};
      vecs[9]  = '{0, 1'b1, 32'h0001_000C, 3'd7, 5'h09, 4'd1, 1'b1, 1'b1, 3'd3};
      vecs[10] = '{0, 1'b0, 32'h0000_0000, 3'd7, 5'h1F, 4'd1, 1'b0, 1'b0, 3'd0};
      vecs[11] = '{1, 1'b0, 32'h0000_0080, 3'd1, 5'h1F, 4'd1, 1'b1, 1'b1, 3'd0};
      vecs[12] = '{0, 1'b0, 32'h0000_0040, 3'd1, 5'h1F, 4'd1, 1'b0, 1'b0, 3'd0};
      vecs[13] = '{1, 1'b1, 32'h0000_0010, 3'd4, 5'h1F, 4'd1, 1'b1, 1'b1, 3'd1};
      vecs[14] = '{0, 1'b0, 32'h0000_0006, 3'd7, 5'h08, 4'd1, 1'b1, 1'b1, 3'd3};
      vecs[15] = '{0, 1'b0, 32'h0000_000E, 3'd7, 5'h11, 4'd1, 1'b1, 1'b1, 3'd0};

      // Reset.
      rst_n = 1'b0;
      cfg_en = 1'b0; cfg_rate = '0; cfg_type_mask = '0; cfg_burst = '0; cfg_seed = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      check("rst_inj_active", 32'(inj_active), 0);
      check("rst_inj_type", 32'(inj_type), 0);
      check("rst_inj_seed", inj_seed, 0);
      check("rst_err_failed", 32'(err_failed), 0);
      check("rst_inj_cnt", 32'(inj_cnt), 0);
      check("rst_fail_cnt", 32'(fail_cnt), 0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      rst_n = 1'b1;
      tick();

      // rate=0: no injection over a random access stream.
      sb_on = 1'b1;
      cfg_en = 1'b1; cfg_rate = 3'd0; cfg_type_mask = 5'h1F; cfg_burst = 4'd1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         acc_valid  = 2'($urandom_range(0, 3));
         acc_done   = acc_valid & 2'($urandom_range(0, 3));
         acc_is_cap = 2'($urandom_range(0, 3));
         @(negedge clk);
         if (inj_active != '0) bad++;
         tick();
      end
      idle_inputs();
      @(negedge clk);
      check("rate0_active_cycles", bad, 0);
      check("rate0_inj_cnt", 32'(inj_cnt), 0);
      check("rate0_state", 32'(dbg_state), 32'(ST_IDLE));
      tick();

      // Vector table: arm with a known seed, inject on the following cycle.
      for (int v = 0; v < 16; v++) begin
         flush();
         idle_inputs();
         cfg_rate = vecs[v].rate; cfg_type_mask = vecs[v].mask; cfg_burst = vecs[v].burst;
         load_seed(vecs[v].seed);
         acc_valid[vecs[v].ch] = 1'b1; acc_done[vecs[v].ch] = 1'b1;
         acc_is_cap[vecs[v].ch] = vecs[v].cap;
         tick();
         acc_done = '0;
         @(negedge clk);
         check($sformatf("vec%0d_arm_state", v), 32'(dbg_state),
               32'(vecs[v].arms ? ST_ARMED : ST_IDLE));
         if (vecs[v].arms) begin
            tick();
            @(negedge clk);
            check($sformatf("vec%0d_inj_state", v), 32'(dbg_state),
                  32'(vecs[v].injects ? ST_INJECT : ST_ARMED));
            if (vecs[v].injects) begin
               check($sformatf("vec%0d_active", v), 32'(inj_active), 32'(1 << vecs[v].ch));
               check($sformatf("vec%0d_seed", v), inj_seed, vecs[v].seed);
               tick();
               expect_inj(vecs[v].ch, vecs[v].typ);
               acc_done[vecs[v].ch] = 1'b1;
               tick();
               idle_inputs();
               @(negedge clk);
               check($sformatf("vec%0d_done_state", v), 32'(dbg_state), 32'(ST_IDLE));
               check($sformatf("vec%0d_inj_cnt", v), 32'(inj_cnt), sat(exp_inj_total));
            end else begin
               check($sformatf("vec%0d_no_active", v), 32'(inj_active), 0);
               tick();
               cfg_en = 1'b0;
               tick();
               cfg_en = 1'b1;
               @(negedge clk);
               check($sformatf("vec%0d_disable_state", v), 32'(dbg_state), 32'(ST_IDLE));
            end
         end
         idle_inputs();
         tick();
      end

      // LFSR-driven RV32 stream with only tag faults enabled.
      sb_on = 1'b0;
      flush();
      cfg_rate = 3'd7; cfg_type_mask = 5'h01; cfg_burst = 4'd1;
      load_seed(32'h1);
      n_inj = 0;
      for (int i = 0; i < 40; i++) begin
         acc_valid[0] = 1'b1;
         tick();
         acc_done[0] = 1'b1;
         @(negedge clk);
         if (inj_active[0]) begin
            n_inj++;
            check("t2_type", 32'(inj_type), 0);
         end
         tick();
         idle_inputs();
         tick();
      end
      exp_inj_total += n_inj;
      check("t2_some_inj", 32'(n_inj != 0), 1);
      check("t2_inj_cnt", 32'(inj_cnt), sat(exp_inj_total));
      sb_on = 1'b1;

      // Burst of 3: three consecutive accesses injected without re-rolling.
      flush();
      cfg_rate = 3'd7; cfg_type_mask = 5'h01; cfg_burst = 4'd3;
      load_seed(32'h4);
      arm(0, 1'b0);
      @(negedge clk);
      check("burst_armed", 32'(dbg_state), 32'(ST_ARMED));
      for (int k = 0; k < 3; k++) begin
         expect_inj(0, 3'd0);
         inject_access(0);
         @(negedge clk);
         check($sformatf("burst_state_%0d", k), 32'(dbg_state),
               32'((k < 2) ? ST_ARMED : ST_IDLE));
      end
      check("burst_inj_cnt", 32'(inj_cnt), sat(exp_inj_total));
      acc_valid[0] = 1'b1;
      tick();
      acc_done[0] = 1'b1;
      @(negedge clk);
      check("burst_fourth_idle", 32'(inj_active), 0);
      tick();
      idle_inputs();
      tick();

      // ISR holds off the injection; ISR start inside INJECT drops the strobe.
      flush();
      cfg_burst = 4'd1; cfg_type_mask = 5'h1F;
      load_seed(32'h4);
      arm(1, 1'b0);
      in_isr = 1'b1;
      acc_valid[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("isr_hold_active_%0d", k), 32'(inj_active), 0);
         check($sformatf("isr_hold_state_%0d", k), 32'(dbg_state), 32'(ST_ARMED));
         tick();
      end
      in_isr = 1'b0;
      tick();
      @(negedge clk);
      check("isr_exit_active", 32'(inj_active), 32'h2);
      in_isr = 1'b1;
      #1;
      check("isr_mid_inject", 32'(inj_active), 0);
      in_isr = 1'b0;
      tick();
      expect_inj(1, 3'd0);
      acc_done[1] = 1'b1;
      tick();
      idle_inputs();
      tick();

      // ARMED timeout after ARM_TO cycles with no access.
      flush();
      load_seed(32'h4);
      base_cnt = exp_inj_total;
      arm(0, 1'b0);
      repeat (ARM_TO - 1) tick();
      @(negedge clk);
      check("to_still_armed", 32'(dbg_state), 32'(ST_ARMED));
      tick();
      @(negedge clk);
      check("to_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("to_inj_cnt", 32'(inj_cnt), sat(base_cnt));

      // Untrapped injection reported once; skip and trapped cases are silent.
      flush();
      load_seed(32'h4);
      arm(0, 1'b0);
      acc_valid[0] = 1'b1;
      tick();
      lsu_req = 1'b1;
      @(negedge clk);
      check("fail_no_pulse_yet", 32'(err_failed), 0);
      tick();
      @(negedge clk);
      check("fail_pulse", 32'(err_failed), 1);
      check("fail_cnt_1", 32'(fail_cnt), 1);
      tick();
      acc_done[0] = 1'b1; lsu_req = 1'b0;
      expect_inj(0, 3'd0);
      @(negedge clk);
      check("fail_once", 32'(err_failed), 0);
      check("fail_cnt_still_1", 32'(fail_cnt), 1);
      tick();
      idle_inputs();
      tick();

      load_seed(32'h4);
      arm(0, 1'b0);
      acc_valid[0] = 1'b1;
      tick();
      lsu_req = 1'b1; skip_chk = 1'b1;
      tick();
      skip_chk = 1'b0; lsu_cheri_err = 1'b1;
      @(negedge clk);
      check("skip_no_pulse", 32'(err_failed), 0);
      tick();
      acc_done[0] = 1'b1; lsu_req = 1'b0; lsu_cheri_err = 1'b0;
      expect_inj(0, 3'd0);
      @(negedge clk);
      check("trapped_no_pulse", 32'(err_failed), 0);
      check("skip_fail_cnt", 32'(fail_cnt), 1);
      tick();
      idle_inputs();
      tick();

      load_seed(32'h4);
      arm(0, 1'b0);
      acc_valid[0] = 1'b1;
      tick();
      lsu_req = 1'b1;
      tick();
      acc_done[0] = 1'b1; lsu_req = 1'b0;
      expect_inj(0, 3'd0);
      @(negedge clk);
      check("fail_second_pulse", 32'(err_failed), 1);
      check("fail_cnt_2", 32'(fail_cnt), 2);
      tick();
      idle_inputs();
      tick();

      // Simultaneous completions in IDLE: channel 0 wins.
      flush();
      load_seed(32'h4);
      acc_valid = 2'b11; acc_done = 2'b11;
      tick();
      acc_done = '0; acc_valid = 2'b10;
      tick();
      @(negedge clk);
      check("dual_ch1_ignored_state", 32'(dbg_state), 32'(ST_ARMED));
      check("dual_ch1_ignored_active", 32'(inj_active), 0);
      acc_valid = 2'b01;
      tick();
      acc_done = 2'b01;
      expect_inj(0, 3'd0);
      @(negedge clk);
      check("dual_ch0_active", 32'(inj_active), 32'h1);
      tick();
      idle_inputs();
      tick();

      // Completion in the same cycle enable falls: no count.
      load_seed(32'h4);
      base_cnt = exp_inj_total;
      arm(0, 1'b0);
      acc_valid[0] = 1'b1;
      tick();
      cfg_en = 1'b0; acc_done[0] = 1'b1;
      @(negedge clk);
      check("endrop_active", 32'(inj_active), 0);
      tick();
      cfg_en = 1'b1;
      idle_inputs();
      @(negedge clk);
      check("endrop_state", 32'(dbg_state), 32'(ST_IDLE));
      check("endrop_inj_cnt", 32'(inj_cnt), sat(base_cnt));
      tick();

      // Drive the injection counter into saturation.
      cfg_type_mask = 5'h01; cfg_burst = 4'd15;
      while (exp_inj_total <= CNT_MAX + 5) begin
         flush();
         load_seed(32'h4);
         arm(0, 1'b0);
         for (int k = 0; k < 15; k++) begin
            expect_inj(0, 3'd0);
            inject_access(0);
         end
      end
      @(negedge clk);
      check("sat_inj_cnt", 32'(inj_cnt), sat(exp_inj_total));
      check("sat_state", 32'(dbg_state), 32'(ST_IDLE));

      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
